// File: rtl/rpn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rpn_pkg
// Brief    : Shared opcodes, error codes and FSM state encodings for the RPN
//            sequencer and its ALU.
// Revision : 1.0 - initial release
// ============================================================================
package rpn_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_OUT  = 3'd5;
    localparam logic [2:0] OP_DROP = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    localparam logic [1:0] ERR_OVF = 2'd1;
    localparam logic [1:0] ERR_UNF = 2'd2;
    localparam logic [1:0] ERR_ILL = 2'd3;

    localparam int         c_ST_W       = 3;
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_POP_B   = 3'd1;
    localparam logic [2:0] c_ST_WAIT_B  = 3'd2;
    localparam logic [2:0] c_ST_POP_A   = 3'd3;
    localparam logic [2:0] c_ST_WAIT_A  = 3'd4;
    localparam logic [2:0] c_ST_EXEC    = 3'd5;
    localparam logic [2:0] c_ST_PUSH    = 3'd6;

    // Two-operand opcodes consume A and B and push a result.
    function automatic logic is_binary(input logic [2:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rpn_sequencer_alu.sv
`default_nettype none
// ============================================================================
// Module   : rpn_alu
// Brief    : Combinational ALU, A is the deeper operand, B the top of stack.
// Revision : 1.0 - initial release
// ============================================================================
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [2:0]    i_op,
    output logic [DW-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rpn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rpn_sequencer
// Brief    : Reverse Polish token evaluator driving an external LIFO stack.
// Revision : 1.0 - initial release
// ============================================================================
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tok_valid,
    output logic                         tok_ready,
    input  logic                         tok_is_op,
    input  logic [DW-1:0]                tok_data,
    output logic                         res_valid,
    output logic [DW-1:0]                res_data,
    output logic                         err_valid,
    output logic [1:0]                   err_code,
    output logic                         err_sticky,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         stk_push,
    output logic                         stk_pop,
    output logic [DW-1:0]                stk_data_in,
    input  logic [DW-1:0]                stk_data_out,
    input  logic                         stk_error
);

    localparam int                    c_DEPTH_W = $clog2(DEPTH+1);
    localparam logic [c_DEPTH_W-1:0]  c_FULL    = c_DEPTH_W'(DEPTH);
    localparam logic [c_DEPTH_W-1:0]  c_ONE     = c_DEPTH_W'(1);
    localparam logic [c_DEPTH_W-1:0]  c_TWO     = c_DEPTH_W'(2);

    logic [c_ST_W-1:0]    r_state, w_next_state;
    logic [2:0]           r_op, w_op;
    logic [DW-1:0]        r_a, w_a, r_b, w_b;
    logic [DW-1:0]        r_stk_data_in, w_stk_data_in;
    logic [DW-1:0]        r_res_data, w_res_data;
    logic                 w_res_valid, r_res_valid;
    logic                 w_err_valid, r_err_valid;
    logic [1:0]           r_err_code, w_err_code;
    logic                 r_err_sticky;
    logic [c_DEPTH_W-1:0] r_depth, w_depth;
    logic                 r_stk_push, r_stk_pop, r_tok_ready;
    logic [DW-1:0]        w_alu_result;
    logic [2:0]           w_tok_op;

    assign w_tok_op = tok_data[2:0];

    rpn_alu #(.DW(DW)) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_alu_result)
    );

    always_comb begin
        w_next_state  = r_state;
        w_op          = r_op;
        w_a           = r_a;
        w_b           = r_b;
        w_stk_data_in = r_stk_data_in;
        w_res_valid   = 1'b0;
        w_res_data    = r_res_data;
        w_err_valid   = 1'b0;
        w_err_code    = r_err_code;
        w_depth       = r_depth;
        case (r_state)
            c_ST_IDLE: begin
                if (tok_valid && r_tok_ready) begin
                    if (!tok_is_op) begin
                        if (r_depth == c_FULL) begin
                            w_err_valid = 1'b1;
                            w_err_code  = ERR_OVF;
                        end else begin
                            w_stk_data_in = tok_data;
                            w_next_state  = c_ST_PUSH;
                        end
                    end else if (w_tok_op == OP_ILL) begin
                        w_err_valid = 1'b1;
                        w_err_code  = ERR_ILL;
                    end else if ((is_binary(w_tok_op) && r_depth >= c_TWO) ||
                                 (!is_binary(w_tok_op) && r_depth >= c_ONE)) begin
                        w_op         = w_tok_op;
                        w_next_state = c_ST_POP_B;
                    end else begin
                        w_err_valid = 1'b1;
                        w_err_code  = ERR_UNF;
                    end
                end
            end
            c_ST_POP_B: begin
                w_depth      = r_depth - c_ONE;
                w_next_state = c_ST_WAIT_B;
            end
            c_ST_WAIT_B: begin
                w_b = stk_data_out;
                if (r_op == OP_OUT) begin
                    w_res_valid  = 1'b1;
                    w_res_data   = stk_data_out;
                    w_next_state = c_ST_IDLE;
                end else if (r_op == OP_DROP) begin
                    w_next_state = c_ST_IDLE;
                end else begin
                    w_next_state = c_ST_POP_A;
                end
            end
            c_ST_POP_A: begin
                w_depth      = r_depth - c_ONE;
                w_next_state = c_ST_WAIT_A;
            end
            c_ST_WAIT_A: begin
                w_a          = stk_data_out;
                w_next_state = c_ST_EXEC;
            end
            c_ST_EXEC: begin
                w_stk_data_in = w_alu_result;
                w_next_state  = c_ST_PUSH;
            end
            c_ST_PUSH: begin
                w_depth      = r_depth + c_ONE;
                w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Stack strobes are decoded from the next state so they are registered
    // and coincide exactly with the POP_*/PUSH state cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_stk_data_in <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_err_valid   <= 1'b0;
            r_err_code    <= '0;
            r_err_sticky  <= 1'b0;
            r_depth       <= '0;
            r_stk_push    <= 1'b0;
            r_stk_pop     <= 1'b0;
            r_tok_ready   <= 1'b1;
        end else begin
            r_state       <= w_next_state;
            r_op          <= w_op;
            r_a           <= w_a;
            r_b           <= w_b;
            r_stk_data_in <= w_stk_data_in;
            r_res_valid   <= w_res_valid;
            r_res_data    <= w_res_data;
            r_err_valid   <= w_err_valid;
            r_err_code    <= w_err_code;
            r_err_sticky  <= r_err_sticky | w_err_valid | stk_error;
            r_depth       <= w_depth;
            r_stk_push    <= (w_next_state == c_ST_PUSH);
            r_stk_pop     <= (w_next_state == c_ST_POP_B) || (w_next_state == c_ST_POP_A);
            r_tok_ready   <= (w_next_state == c_ST_IDLE);
        end
    end

    assign tok_ready   = r_tok_ready;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign err_valid   = r_err_valid;
    assign err_code    = r_err_code;
    assign err_sticky  = r_err_sticky;
    assign depth       = r_depth;
    assign stk_push    = r_stk_push;
    assign stk_pop     = r_stk_pop;
    assign stk_data_in = r_stk_data_in;

endmodule
`default_nettype wire

// File: tb/tb_rpn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rpn_sequencer
// Brief    : Scoreboard bench for rpn_sequencer with a behavioural LIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rpn_sequencer;
    import rpn_pkg::*;

    localparam int DEPTH   = 16;
    localparam int DW      = 8;
    localparam int DEPTH_W = $clog2(DEPTH+1);

    logic               clk = 1'b0;
    logic               reset;
    logic               tok_valid, tok_ready, tok_is_op;
    logic [DW-1:0]      tok_data;
    logic               res_valid;
    logic [DW-1:0]      res_data;
    logic               err_valid;
    logic [1:0]         err_code;
    logic               err_sticky;
    logic [DEPTH_W-1:0] depth;
    logic               stk_push, stk_pop;
    logic [DW-1:0]      stk_data_in, stk_data_out;
    logic               stk_error;

    always #5 clk = ~clk;

    rpn_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_op    (tok_is_op),
        .tok_data     (tok_data),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .err_valid    (err_valid),
        .err_code     (err_code),
        .err_sticky   (err_sticky),
        .depth        (depth),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_error    (stk_error)
    );

    // Behavioural downstream LIFO; data_out valid the cycle after a pop.
    logic [DW-1:0] mem [DEPTH];
    int            sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp           <= 0;
            stk_data_out <= '0;
        end else if (stk_push && sp < DEPTH) begin
            mem[sp] <= stk_data_in;
            sp      <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_data_out <= mem[sp-1];
            sp           <= sp - 1;
        end
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    int            pop_cnt = 0;
    logic [DW-1:0] q_res[$];
    logic [DW-1:0] q_push[$];
    logic [1:0]    q_err[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got unexpected value %0h, expected none", name, act);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (stk_push && stk_pop) unexpected("push_pop_together", 32'h1);
            if (stk_pop) pop_cnt++;
            if (res_valid) begin
                if (q_res.size() == 0) unexpected("res_data", 32'(res_data));
                else check("res_data", 32'(res_data), 32'(q_res.pop_front()));
            end
            if (err_valid) begin
                if (q_err.size() == 0) unexpected("err_code", 32'(err_code));
                else check("err_code", 32'(err_code), 32'(q_err.pop_front()));
            end
            if (stk_push) begin
                if (q_push.size() == 0) unexpected("stk_data_in", 32'(stk_data_in));
                else check("stk_data_in", 32'(stk_data_in), 32'(q_push.pop_front()));
            end
        end
    end

    task automatic send(input logic is_op, input logic [DW-1:0] d);
        int t = 0;
        @(negedge clk);
        while (!tok_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!tok_ready) begin
            unexpected("tok_ready_timeout", 32'h0);
            return;
        end
        tok_valid = 1'b1;
        tok_is_op = is_op;
        tok_data  = d;
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
    endtask

    task automatic lit(input logic [DW-1:0] v);
        q_push.push_back(v);
        send(1'b0, v);
    endtask

    task automatic op(input logic [2:0] o);
        send(1'b1, {{(DW-3){1'b0}}, o});
    endtask

    task automatic settle();
        int t = 0;
        @(negedge clk);
        while (!tok_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!tok_ready) unexpected("settle_timeout", 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic check_queues_empty(input string tag);
        check({tag, "_res_q"}, 32'(q_res.size()), 32'd0);
        check({tag, "_err_q"}, 32'(q_err.size()), 32'd0);
        check({tag, "_push_q"}, 32'(q_push.size()), 32'd0);
    endtask

    initial begin
        int pc;
        reset     = 1'b1;
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = '0;
        stk_error = 1'b0;
        #12;
        check("rst_tok_ready", 32'(tok_ready), 32'd1);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_outputs", {27'd0, stk_push, stk_pop, res_valid, err_valid, err_sticky}, 32'd0);
        #10 reset = 1'b0;

        // 5 3 ADD OUT -> 8
        lit(8'h05);
        lit(8'h03);
        q_push.push_back(8'h08);
        op(OP_ADD);
        q_res.push_back(8'h08);
        op(OP_OUT);
        settle();
        check("add_depth", 32'(depth), 32'd0);
        check_queues_empty("add");

        // 3 5 SUB OUT -> FE
        lit(8'h03);
        lit(8'h05);
        q_push.push_back(8'hFE);
        op(OP_SUB);
        q_res.push_back(8'hFE);
        op(OP_OUT);
        settle();
        check("sub_sticky", 32'(err_sticky), 32'd0);
        check("sub_depth", 32'(depth), 32'd0);

        // fill to capacity, then overflow
        for (int i = 0; i < DEPTH; i++) lit(8'(i));
        q_err.push_back(ERR_OVF);
        send(1'b0, 8'hAA);
        settle();
        check("ovf_depth", 32'(depth), 32'd16);
        check("ovf_stack_fill", 32'(sp), 32'd16);
        check("ovf_sticky", 32'(err_sticky), 32'd1);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            q_res.push_back(8'(i));
            op(OP_OUT);
        end
        settle();
        check("drain_depth", 32'(depth), 32'd0);
        check_queues_empty("drain");

        // underflow on empty and on a single entry
        pc = pop_cnt;
        q_err.push_back(ERR_UNF);
        op(OP_ADD);
        settle();
        check("unf0_depth", 32'(depth), 32'd0);
        lit(8'h07);
        q_err.push_back(ERR_UNF);
        op(OP_XOR);
        settle();
        check("unf1_depth", 32'(depth), 32'd1);
        check("unf_no_pop", 32'(pop_cnt), 32'(pc));
        op(OP_DROP);
        settle();
        check("drop_depth", 32'(depth), 32'd0);
        check("drop_stack", 32'(sp), 32'd0);

        // illegal opcode from a clean reset
        do_reset();
        check("pre_ill_sticky", 32'(err_sticky), 32'd0);
        q_err.push_back(ERR_ILL);
        op(OP_ILL);
        settle();
        check("ill_code_held", 32'(err_code), 32'(ERR_ILL));
        check("ill_sticky", 32'(err_sticky), 32'd1);

        // stack error pulse sets the sticky flag
        do_reset();
        check("pre_stkerr_sticky", 32'(err_sticky), 32'd0);
        @(negedge clk) stk_error = 1'b1;
        @(negedge clk) stk_error = 1'b0;
        @(negedge clk);
        check("stkerr_sticky", 32'(err_sticky), 32'd1);
        check("stkerr_no_errvalid", 32'(q_err.size()), 32'd0);

        // reset in WAIT_A of an AND
        do_reset();
        lit(8'h10);
        lit(8'h20);
        op(OP_AND);
        repeat (3) @(posedge clk);
        #1;
        check("waita_depth", 32'(depth), 32'd0);
        reset = 1'b1;
        #1;
        check("abort_outputs", {26'd0, stk_push, stk_pop, res_valid, err_valid, err_sticky, 1'b0}, 32'd0);
        check("abort_tok_ready", 32'(tok_ready), 32'd1);
        check("abort_depth", 32'(depth), 32'd0);
        check("abort_data", {16'd0, stk_data_in, err_code, 6'd0}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        lit(8'hFF);
        q_res.push_back(8'hFF);
        op(OP_OUT);
        settle();
        check("final_depth", 32'(depth), 32'd0);
        check_queues_empty("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
